// File: rtl/tx_skp_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_skp_scheduler_if
// MAC data beat handshake into the transmit SKP scheduler.
//   Data_In    [31:0] MAC data beat, byte 0 in [7:0] transmitted first
//   DataK_In   [3:0]  per-byte K flag for Data_In
//   Data_Valid        beat present
//   Data_Last         final beat of a packet (qualified by Data_Valid)
//   Data_Ready        beat accepted when Data_Valid & Data_Ready
// master: MAC side (drives the beat); slave: scheduler (drives Data_Ready).
// ---------------------------------------------------------------------------
interface tx_skp_scheduler_if;
    logic [31:0] Data_In;
    logic [3:0]  DataK_In;
    logic        Data_Valid;
    logic        Data_Last;
    logic        Data_Ready;

    modport master (
        output Data_In,
        output DataK_In,
        output Data_Valid,
        output Data_Last,
        input  Data_Ready
    );

    modport slave (
        input  Data_In,
        input  DataK_In,
        input  Data_Valid,
        input  Data_Last,
        output Data_Ready
    );
endinterface

// File: rtl/tx_skp_scheduler.sv
// ---------------------------------------------------------------------------
// tx_skp_scheduler
// MAC-side transmit scheduler in front of the PHY TX datapath. Merges framed
// MAC data beats with periodic SKP ordered sets (COM K28.5 + 3x SKP K28.0),
// inserted only between packets, at the lane width given by DataBusWidth.
//
// Build option: macro TX_SKP_INSERT_EN enables SKP insertion. When it is not
// defined the block is a one-cycle registered pass-through of Data_In,
// DataK_In and Data_Valid, Data_Ready is 1 and Skp_Overflow is 0.
//
// Parameters:
//   SKP_INTERVAL  PCLK cycles between SKP scheduling events (8..65535)
//   PEND_MAX      saturation value of the pending-SKP counter
// Ports:
//   PCLK          clock, rising edge
//   Reset_n       asynchronous active-low reset
//   DataBusWidth  lane width in bits: 8, 16, otherwise treated as 32
//   s_tx          MAC beat handshake (slave modport)
//   MAC_TX_Data   registered word to PHY
//   MAC_TX_DataK  registered per-byte K flags to PHY
//   MAC_Data_En   registered output word valid
//   Skp_Overflow  sticky: event seen with pending already at PEND_MAX
// ---------------------------------------------------------------------------
module tx_skp_scheduler #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned PEND_MAX     = 3
) (
    input  logic              PCLK,
    input  logic              Reset_n,
    input  logic [5:0]        DataBusWidth,
    tx_skp_scheduler_if.slave s_tx,
    output logic [31:0]       MAC_TX_Data,
    output logic [3:0]        MAC_TX_DataK,
    output logic              MAC_Data_En,
    output logic              Skp_Overflow
);

`ifdef TX_SKP_INSERT_EN
    localparam int unsigned PW = (PEND_MAX < 2) ? 1 : $clog2(PEND_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_SKP} state_t;
    typedef enum logic [1:0] {W_8, W_16, W_32} width_t;

    state_t        r_state;
    state_t        w_state_nxt;
    width_t        r_skp_w;
    width_t        w_eff_w;
    logic [15:0]   r_cnt;
    logic [PW-1:0] r_pend;
    logic [1:0]    r_grp;
    logic          r_ovf;
    logic [31:0]   r_data;
    logic [3:0]    r_datak;
    logic          r_en;

    logic          w_event;
    logic          w_last_grp;
    logic          w_pend_nz;
    logic          w_ready;
    logic          w_accept;
    logic          w_enter_skp;
    logic          w_nxt_en;
    logic [31:0]   w_nxt_data;
    logic [3:0]    w_nxt_k;

    assign w_event        = (r_cnt == 16'(SKP_INTERVAL - 1));
    assign w_pend_nz      = (r_pend != '0);
    assign w_accept       = s_tx.Data_Valid & w_ready;
    assign s_tx.Data_Ready = w_ready;
    assign Skp_Overflow   = r_ovf;
    assign MAC_TX_Data    = r_data;
    assign MAC_TX_DataK   = r_datak;
    assign MAC_Data_En    = r_en;

    always_comb begin
        case (DataBusWidth)
            6'd8:    w_eff_w = W_8;
            6'd16:   w_eff_w = W_16;
            default: w_eff_w = W_32;
        endcase
    end

    // Final group of the ordered set at the width latched on SKP entry.
    always_comb begin
        w_last_grp = 1'b0;
        if (r_state == ST_SKP) begin
            case (r_skp_w)
                W_8:     w_last_grp = (r_grp == 2'd3);
                W_16:    w_last_grp = (r_grp == 2'd1);
                default: w_last_grp = 1'b1;
            endcase
        end
    end

    // Interval counter: 0..SKP_INTERVAL-1, each wrap is a scheduling event.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (w_event) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Pending count: event and completed ordered set in the same cycle cancel.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_event && !w_last_grp) begin
                if (r_pend != PW'(PEND_MAX)) begin
                    r_pend <= r_pend + PW'(1);
                end
            end else if (w_last_grp && !w_event) begin
                r_pend <= r_pend - PW'(1);
            end
            if (w_event && (r_pend == PW'(PEND_MAX))) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Group index and width captured on SKP entry.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_grp   <= '0;
            r_skp_w <= W_32;
        end else begin
            if (w_enter_skp) begin
                r_skp_w <= w_eff_w;
            end
            if ((r_state == ST_SKP) && !w_last_grp) begin
                r_grp <= r_grp + 2'd1;
            end else begin
                r_grp <= '0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_nz) begin
                    w_state_nxt = ST_SKP;
                end else if (w_accept && !s_tx.Data_Last) begin
                    w_state_nxt = ST_PKT;
                end
            end
            ST_PKT: begin
                if (w_accept && s_tx.Data_Last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SKP: begin
                if (w_last_grp) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs (handshake and next output word)
    always_comb begin
        w_ready     = 1'b0;
        w_enter_skp = 1'b0;
        w_nxt_en    = 1'b0;
        w_nxt_data  = '0;
        w_nxt_k     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_nz) begin
                    w_enter_skp = 1'b1;
                end else begin
                    w_ready = 1'b1;
                end
            end
            ST_PKT: w_ready = 1'b1;
            ST_SKP: begin
                w_nxt_en = 1'b1;
                case (r_skp_w)
                    W_8: begin
                        w_nxt_data = (r_grp == 2'd0) ? 32'h0000_00BC : 32'h0000_001C;
                        w_nxt_k    = 4'b0001;
                    end
                    W_16: begin
                        w_nxt_data = (r_grp == 2'd0) ? 32'h0000_1CBC : 32'h0000_1C1C;
                        w_nxt_k    = 4'b0011;
                    end
                    default: begin
                        w_nxt_data = 32'h1C1C_1CBC;
                        w_nxt_k    = 4'b1111;
                    end
                endcase
            end
            default: ;
        endcase
        if (w_accept) begin
            w_nxt_en   = 1'b1;
            w_nxt_data = s_tx.Data_In;
            w_nxt_k    = s_tx.DataK_In;
        end
    end

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data  <= '0;
            r_datak <= '0;
            r_en    <= 1'b0;
        end else begin
            r_data  <= w_nxt_data;
            r_datak <= w_nxt_k;
            r_en    <= w_nxt_en;
        end
    end
`else
    logic [31:0] r_data;
    logic [3:0]  r_datak;
    logic        r_en;
    logic        w_unused;

    assign w_unused        = &{1'b0, DataBusWidth, s_tx.Data_Last,
                               32'(SKP_INTERVAL), 32'(PEND_MAX)};
    assign s_tx.Data_Ready = 1'b1;
    assign Skp_Overflow    = 1'b0;
    assign MAC_TX_Data     = r_data;
    assign MAC_TX_DataK    = r_datak;
    assign MAC_Data_En     = r_en;

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data  <= '0;
            r_datak <= '0;
            r_en    <= 1'b0;
        end else begin
            r_data  <= s_tx.Data_In;
            r_datak <= s_tx.DataK_In;
            r_en    <= s_tx.Data_Valid;
        end
    end
`endif

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_skp_scheduler
// Self-checking bench for tx_skp_scheduler (SKP_INTERVAL=16, PEND_MAX=3).
// A short vector table checks reset-time pass-through, then a queue-based
// reference model checks every cycle of the directed and random sequences.
// SKP sequences are built only when TX_SKP_INSERT_EN is defined.
// ---------------------------------------------------------------------------
module tb_tx_skp_scheduler;
    localparam int unsigned SKP_INT = 16;
    localparam int unsigned PMAX    = 3;

    logic        PCLK = 1'b0;
    logic        Reset_n = 1'b1;
    logic [5:0]  DataBusWidth;
    logic [31:0] MAC_TX_Data;
    logic [3:0]  MAC_TX_DataK;
    logic        MAC_Data_En;
    logic        Skp_Overflow;

    tx_skp_scheduler_if tif ();

    tx_skp_scheduler #(
        .SKP_INTERVAL (SKP_INT),
        .PEND_MAX     (PMAX)
    ) dut (
        .PCLK         (PCLK),
        .Reset_n      (Reset_n),
        .DataBusWidth (DataBusWidth),
        .s_tx         (tif),
        .MAC_TX_Data  (MAC_TX_Data),
        .MAC_TX_DataK (MAC_TX_DataK),
        .MAC_Data_En  (MAC_Data_En),
        .Skp_Overflow (Skp_Overflow)
    );

    initial forever #5 PCLK = ~PCLK;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    word_t       m_skq[$];     // ordered-set words still to be sent
    int unsigned m_cnt;        // cycles since last scheduling event
    int unsigned m_pend;
    bit          m_ovf;
    bit          m_inpkt;
    int unsigned m_edges;      // rising edges since reset release

    bit          obs_en;
    logic [31:0] obs_d;
    logic [3:0]  obs_k;

    task automatic model_reset();
        m_skq.delete();
        m_cnt   = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        m_inpkt = 1'b0;
        m_edges = 0;
    endtask

    task automatic model_step(input bit v, input bit l, input logic [31:0] d,
                              input logic [3:0] k, input logic [5:0] w,
                              output bit rdy, output bit en,
                              output logic [31:0] od, output logic [3:0] ok);
`ifdef TX_SKP_INSERT_EN
        bit    ev;
        bit    dec;
        word_t x;
        rdy = (m_skq.size() == 0) && (m_inpkt || (m_pend == 0));
        en  = 1'b0;
        od  = '0;
        ok  = '0;
        dec = 1'b0;
        if (m_skq.size() != 0) begin
            x   = m_skq.pop_front();
            en  = 1'b1;
            od  = x.d;
            ok  = x.k;
            dec = (m_skq.size() == 0);
        end else if (rdy && v) begin
            en      = 1'b1;
            od      = d;
            ok      = k;
            m_inpkt = !l;
        end else if (!rdy) begin
            // between packets with work pending: queue the whole ordered set
            if (w == 6'd8) begin
                for (int i = 0; i < 4; i++)
                    m_skq.push_back({(i == 0) ? 32'h0000_00BC : 32'h0000_001C, 4'b0001});
            end else if (w == 6'd16) begin
                m_skq.push_back({32'h0000_1CBC, 4'b0011});
                m_skq.push_back({32'h0000_1C1C, 4'b0011});
            end else begin
                m_skq.push_back({32'h1C1C_1CBC, 4'b1111});
            end
        end
        ev    = (m_cnt == SKP_INT - 1);
        m_cnt = ev ? 0 : m_cnt + 1;
        if (ev && (m_pend == PMAX)) m_ovf = 1'b1;
        if (ev && !dec && (m_pend < PMAX)) m_pend++;
        else if (dec && !ev) m_pend--;
`else
        rdy = 1'b1;
        en  = v;
        od  = d;
        ok  = k;
        if (l && (w == 6'd63)) m_inpkt = 1'b1;
`endif
    endtask

    // One clock cycle: drive at negedge, check ready, check outputs after edge.
    task automatic step(input bit v, input bit l, input logic [31:0] d,
                        input logic [3:0] k, input logic [5:0] w);
        bit          rdy;
        bit          en;
        logic [31:0] od;
        logic [3:0]  ok;
        tif.Data_Valid = v;
        tif.Data_Last  = l;
        tif.Data_In    = d;
        tif.DataK_In   = k;
        DataBusWidth   = w;
        #1;
        model_step(v, l, d, k, w, rdy, en, od, ok);
        chk("data_ready", 32'(tif.Data_Ready), 32'(rdy));
        @(posedge PCLK);
        #1;
        m_edges++;
        chk("mac_data_en", 32'(MAC_Data_En), 32'(en));
        chk("mac_tx_data", MAC_TX_Data, od);
        chk("mac_tx_datak", 32'(MAC_TX_DataK), 32'(ok));
        chk("skp_overflow", 32'(Skp_Overflow), 32'(m_ovf));
        obs_en = MAC_Data_En;
        obs_d  = MAC_TX_Data;
        obs_k  = MAC_TX_DataK;
        @(negedge PCLK);
    endtask

    task automatic idle(input int unsigned n, input logic [5:0] w);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, w);
    endtask

    // Asserted away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        tif.Data_Valid = 1'b0;
        tif.Data_Last  = 1'b0;
        tif.Data_In    = '0;
        tif.DataK_In   = '0;
        Reset_n = 1'b0;
        #1;
        chk("rst_en", 32'(MAC_Data_En), 32'd0);
        chk("rst_data", MAC_TX_Data, 32'd0);
        chk("rst_datak", 32'(MAC_TX_DataK), 32'd0);
        chk("rst_ovf", 32'(Skp_Overflow), 32'd0);
        chk("rst_ready", 32'(tif.Data_Ready), 32'd1);
        model_reset();
        @(negedge PCLK);
        @(negedge PCLK);
        Reset_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        bit          l;
        logic [31:0] d;
        logic [3:0]  k;
        bit          e_rdy;
        bit          e_en;
        logic [31:0] e_d;
        logic [3:0]  e_k;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned first;
        int unsigned cnt;
        bit          found;
        bit          prev_bc;
        bit          v;
        bit          l;
        logic [5:0]  w;

        DataBusWidth = 6'd32;
        @(negedge PCLK);
        do_reset();

        // Pass-through of data beats right after reset (no event before edge 16).
        tbl[0] = '{1'b1, 1'b0, 32'hA1A2_A3A4, 4'h0, 1'b1, 1'b1, 32'hA1A2_A3A4, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h1234_5678, 4'h1, 1'b1, 1'b1, 32'h1234_5678, 4'h1};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 4'h0};
        tbl[3] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 4'h8, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h8};
        tbl[4] = '{1'b1, 1'b1, 32'h0F0F_F0F0, 4'h6, 1'b1, 1'b1, 32'h0F0F_F0F0, 4'h6};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 4'h0};
        for (int i = 0; i < 6; i++) begin
            tif.Data_Valid = tbl[i].v;
            tif.Data_Last  = tbl[i].l;
            tif.Data_In    = tbl[i].d;
            tif.DataK_In   = tbl[i].k;
            #1;
            chk("tbl_ready", 32'(tif.Data_Ready), 32'(tbl[i].e_rdy));
            @(posedge PCLK);
            #1;
            chk("tbl_en", 32'(MAC_Data_En), 32'(tbl[i].e_en));
            chk("tbl_data", MAC_TX_Data, tbl[i].e_d);
            chk("tbl_datak", 32'(MAC_TX_DataK), 32'(tbl[i].e_k));
            @(negedge PCLK);
        end

`ifdef TX_SKP_INSERT_EN
        // Idle at W=32: first event at edge 16, SKP entered at edge 17,
        // word visible after edge 18.
        do_reset();
        first = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd32);
            if (obs_en && (first == 0)) begin
                first = m_edges;
                chk("first_skp_word", obs_d, 32'h1C1C_1CBC);
                chk("first_skp_k", 32'(obs_k), 32'hF);
            end
        end
        chk("first_skp_edge", first, 32'd18);

        // W=8 packet straddling the event at edge 16.
        do_reset();
        idle(14, 6'd8);
        step(1'b1, 1'b0, 32'h1111_1111, 4'h0, 6'd8);
        step(1'b1, 1'b0, 32'h2222_2222, 4'h0, 6'd8);
        step(1'b1, 1'b1, 32'h3333_3333, 4'h0, 6'd8);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd8);
            if (obs_en && (obs_k == 4'b0001)) cnt++;
        end
        chk("w8_skp_words", cnt, 32'd4);

        // W=16, width changed to 32 during first SKP word.
        do_reset();
        idle(17, 6'd16);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd32);
            if (m_edges == 19) chk("w16_second_word", obs_d, 32'h0000_1C1C);
            if (obs_en && (obs_k == 4'hF)) cnt++;
        end
        chk("w32_after_change", cnt, 32'd1);

        // Packet held open past PEND_MAX events: saturation and overflow.
        do_reset();
        step(1'b1, 1'b0, 32'hCAFE_0000, 4'h0, 6'd32);
        for (int i = 0; i < 80; i++) begin
            v = ($urandom_range(0, 1) == 1);
            step(v, 1'b0, $urandom, 4'h0, 6'd32);
        end
        chk("overflow_set", 32'(Skp_Overflow), 32'd1);
        step(1'b1, 1'b1, 32'hCAFE_FFFF, 4'h0, 6'd32);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd32);
            if (obs_en && (obs_d == 32'h1C1C_1CBC) && (obs_k == 4'hF)) cnt++;
        end
        chk("saturated_sets", cnt, 32'd3);

        // Reset during the second W=8 SKP word.
        do_reset();
        found   = 1'b0;
        prev_bc = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd8);
            found   = prev_bc && obs_en && (obs_d == 32'h0000_001C);
            prev_bc = obs_en && (obs_d == 32'h0000_00BC);
        end
        chk("second_w8_word_seen", 32'(found), 32'd1);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0, '0, '0, 6'd8);
            if (obs_en) cnt++;
        end
        chk("no_residual_skp", cnt, 32'd0);
        idle(6, 6'd8);
`endif

        // Random traffic against the model.
        do_reset();
        w = 6'd32;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       w = 6'd8;
                    1:       w = 6'd16;
                    2:       w = 6'd32;
                    default: w = 6'd5;
                endcase
            end
            v = ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 3) == 0);
            step(v, l, $urandom, 4'($urandom), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
